// File: rtl/cnt_seq_ctrl_if.sv
// cnt_seq_ctrl_if: control/status bundle for the counter sequencer.
//   start, stop, hold     : command inputs to the sequencer
//   auto_rl, dir, lim, div: configuration, latched by the sequencer on start
//   cnt, busy, tick, tc, done : status returned by the sequencer
//   master drives commands/config, slave drives status
interface cnt_seq_ctrl_if #(parameter int W = 4, parameter int PW = 4);
    logic          start;
    logic          stop;
    logic          hold;
    logic          auto_rl;
    logic          dir;
    logic [W-1:0]  lim;
    logic [PW-1:0] div;
    logic [W-1:0]  cnt;
    logic          busy;
    logic          tick;
    logic          tc;
    logic          done;
    modport master (
        output start, stop, hold, auto_rl, dir, lim, div,
        input  cnt, busy, tick, tc, done
    );
    modport slave (
        input  start, stop, hold, auto_rl, dir, lim, div,
        output cnt, busy, tick, tc, done
    );
endinterface

// File: rtl/cnt_seq_ctrl.sv
// cnt_seq_ctrl: programmable up/down counter sequencer with prescaler and run/hold/done control.
//   clk : clock, all state changes on the falling edge
//   clr : asynchronous active-low reset
//   bus : cnt_seq_ctrl_if slave (start/stop/hold/auto_rl/dir/lim/div in, cnt/busy/tick/tc/done out)
module cnt_seq_ctrl #(
    parameter int W  = 4,
    parameter int PW = 4
) (
    input logic         clk,
    input logic         clr,
    cnt_seq_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;
    state_t        state;
    logic [W-1:0]  lim_l;
    logic [W-1:0]  term;
    logic [W-1:0]  sv;
    logic          dir_l;
    logic          auto_l;
    logic [PW-1:0] div_l;
    logic [PW-1:0] p;
    assign term     = dir_l ? lim_l : '0;
    assign sv       = dir_l ? '0 : lim_l;
    assign bus.tick = state == RUN && p == div_l;
    assign bus.tc   = bus.tick && bus.cnt == term;
    always_ff @(negedge clk or negedge clr) begin
        if (!clr) begin
            state    <= IDLE;
            bus.cnt  <= '0;
            p        <= '0;
            lim_l    <= '0;
            dir_l    <= 1'b1;
            auto_l   <= 1'b0;
            div_l    <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
        end else if (bus.stop) begin
            state    <= IDLE;
            bus.cnt  <= '0;
            p        <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
        end else if (bus.start) begin
            state    <= RUN;
            lim_l    <= bus.lim;
            dir_l    <= bus.dir;
            auto_l   <= bus.auto_rl;
            div_l    <= bus.div;
            bus.cnt  <= bus.dir ? '0 : bus.lim;
            p        <= '0;
            bus.busy <= 1'b1;
            bus.done <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    // hold still lets this edge's step happen; reaching terminal in one-shot overrides it
                    if (bus.hold)
                        state <= HOLD;
                    if (bus.tick) begin
                        p <= '0;
                        if (bus.cnt != term)
                            bus.cnt <= dir_l ? bus.cnt + 1'b1 : bus.cnt - 1'b1;
                        else if (auto_l)
                            bus.cnt <= sv;
                        else begin
                            state    <= DONE;
                            bus.busy <= 1'b0;
                            bus.done <= 1'b1;
                        end
                    end else
                        p <= p + 1'b1;
                end
                HOLD: if (!bus.hold) state <= RUN;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// tb_cnt_seq_ctrl: directed scoreboard bench for cnt_seq_ctrl.
module tb_cnt_seq_ctrl;
    localparam int W  = 4;
    localparam int PW = 4;
    logic clk = 1'b1;
    logic clr = 1'b0;
    cnt_seq_ctrl_if #(.W(W), .PW(PW)) bus ();
    cnt_seq_ctrl #(.W(W), .PW(PW)) dut (.clk(clk), .clr(clr), .bus(bus));
    always #5 clk = ~clk;
    typedef struct packed {
        logic [W-1:0] cnt;
        logic         busy;
        logic         done;
        logic         tick;
        logic         tc;
    } exp_t;
    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic push(input logic [W-1:0] c, input logic b, input logic d, input logic tk, input logic t);
        exp_t e;
        e = '{cnt: c, busy: b, done: d, tick: tk, tc: t};
        sb.push_back(e);
    endtask
    task automatic sample(input string tag);
        exp_t e;
        e = sb.pop_front();
        chk({tag, ".cnt"},  bus.cnt,  e.cnt);
        chk({tag, ".busy"}, W'(bus.busy), W'(e.busy));
        chk({tag, ".done"}, W'(bus.done), W'(e.done));
        chk({tag, ".tick"}, W'(bus.tick), W'(e.tick));
        chk({tag, ".tc"},   W'(bus.tc),   W'(e.tc));
    endtask
    task automatic step(input string tag, input logic [W-1:0] c, input logic b, input logic d,
                        input logic tk, input logic t);
        push(c, b, d, tk, t);
        @(negedge clk);
        #1;
        sample(tag);
    endtask
    task automatic cfg(input logic [W-1:0] l, input logic [PW-1:0] dv, input logic dr, input logic ar);
        bus.lim = l;
        bus.div = dv;
        bus.dir = dr;
        bus.auto_rl = ar;
    endtask
    initial begin
        int u;
        int ph;
        bus.start = 0;
        bus.stop = 0;
        bus.hold = 0;
        cfg(0, 0, 0, 0);
        #2;
        push(0, 0, 0, 0, 0);
        sample("reset");
        clr = 1'b1;
        step("idle0", 0, 0, 0, 0, 0);
        step("idle1", 0, 0, 0, 0, 0);
        // one-shot up, lim=3 div=0
        cfg(3, 0, 1, 0);
        bus.start = 1;
        step("os_start", 0, 1, 0, 1, 0);
        bus.start = 0;
        cfg(9, 5, 0, 1);
        step("os1", 1, 1, 0, 1, 0);
        step("os2", 2, 1, 0, 1, 0);
        step("os3", 3, 1, 0, 1, 1);
        step("os_done", 3, 0, 1, 0, 0);
        step("os_stay", 3, 0, 1, 0, 0);
        // auto-reload down, lim=2 div=2: 9-cycle tc period
        cfg(2, 2, 0, 1);
        bus.start = 1;
        for (int k = 0; k < 27; k++) begin
            ph = k % 9;
            step("ar", W'(2 - ph / 3), 1, 0, (ph % 3) == 2, ph == 8);
            bus.start = 0;
        end
        // hold at cnt=5 for 6 edges, lim=15 div=1 up one-shot
        cfg(15, 1, 1, 0);
        bus.start = 1;
        for (int k = 0; k < 41; k++) begin
            if (k >= 11 && k <= 16)
                step("hold", 5, 1, 0, 0, 0);
            else begin
                u = k < 11 ? k : k - 6;
                if (u <= 31)
                    step("hrun", W'(u / 2), 1, 0, u % 2 == 1, u == 31);
                else
                    step("hdone", 15, 0, 1, 0, 0);
            end
            bus.start = 0;
            if (k == 10) bus.hold = 1;
            if (k == 16) bus.hold = 0;
        end
        // start+stop together during RUN
        cfg(15, 0, 1, 1);
        bus.start = 1;
        step("pr_start", 0, 1, 0, 1, 0);
        bus.start = 0;
        for (int k = 1; k <= 7; k++) step("pr_run", W'(k), 1, 0, 1, 0);
        bus.start = 1;
        bus.stop = 1;
        step("pr_stop", 0, 0, 0, 0, 0);
        bus.stop = 0;
        cfg(15, 0, 1, 0);
        step("rs_start", 0, 1, 0, 1, 0);
        bus.start = 0;
        for (int k = 1; k <= 7; k++) step("rs_run", W'(k), 1, 0, 1, 0);
        cfg(4, 0, 0, 0);
        bus.start = 1;
        step("rs_new", 4, 1, 0, 1, 0);
        bus.start = 0;
        for (int k = 3; k >= 0; k--) step("rs_down", W'(k), 1, 0, 1, k == 0);
        step("rs_done", 0, 0, 1, 0, 0);
        // lim=0 div=0 one-shot
        cfg(0, 0, 1, 0);
        bus.start = 1;
        step("l0_start", 0, 1, 0, 1, 1);
        bus.start = 0;
        step("l0_done", 0, 0, 1, 0, 0);
        // asynchronous reset mid-RUN at cnt=2
        cfg(15, 0, 1, 0);
        bus.start = 1;
        step("ac0", 0, 1, 0, 1, 0);
        bus.start = 0;
        step("ac1", 1, 1, 0, 1, 0);
        step("ac2", 2, 1, 0, 1, 0);
        #2;
        clr = 1'b0;
        #1;
        push(0, 0, 0, 0, 0);
        sample("async_clr");
        #1;
        clr = 1'b1;
        step("post_clr0", 0, 0, 0, 0, 0);
        step("post_clr1", 0, 0, 0, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cnt_seq_ctrl.md
Name: cnt_seq_ctrl

Overview:
- Programmable sequencer for the team's W-bit synchronous counter datapath.
- Owns the count register, a clock prescaler and a run/hold/done state machine.
- Provides start/stop/hold control, up or down counting to a programmable limit, one-shot or auto-reload operation, and terminal-count/done status.
- Used as the timing/scheduling element feeding downstream logic that today instantiates bare counters.

Parameters:
- W, 4, count register and limit width.
- PW, 4, prescaler divider width.

Ports:
- clk  input  1  clock; all state updates on the falling edge (negedge clk), matching existing counter blocks.
- clr  input  1  asynchronous, active-low reset; clr=0 forces the reset state immediately.
- start  input  1  load and begin counting; sampled at the clock edge.
- stop  input  1  abort and return to IDLE.
- hold  input  1  pause while RUN; resume when deasserted.
- auto_rl  input  1  1 = periodic (reload at terminal), 0 = one-shot.
- dir  input  1  1 = up, 0 = down.
- lim  input  W  count limit.
- div  input  PW  prescale: counter steps once every div+1 RUN cycles.
- cnt  output  W  current count.
- busy  output  1  high in RUN or HOLD.
- tick  output  1  prescaler strobe. Combinational: state==RUN && p==div_l.
- tc  output  1  terminal-count pulse. Combinational: tick && cnt==term.
- done  output  1  level, high in DONE.

Behaviour:
- Reset (clr=0):
  - state=IDLE, cnt=0, p=0.
  - Latched config cleared: lim_l=0, dir_l=1, auto_l=0, div_l=0.
  - Outputs: busy=0, tick=0, tc=0, done=0.
- States: IDLE, RUN, HOLD, DONE. Priority at each edge is stop > start > hold.
- start (any state):
  - Latch lim, dir, auto_rl, div into lim_l, dir_l, auto_l, div_l.
  - Load cnt = 0 if dir=1, else lim. Set p=0. Go to RUN.
  - start while RUN or HOLD restarts cleanly.
- Inputs lim, dir, auto_rl and div are ignored except at start.
- stop (any state): go to IDLE, cnt=0, p=0. stop takes priority over start in the same cycle.
- Terminal value: term = lim_l if dir_l=1, else 0. Start value: sv = 0 if dir_l=1, else lim_l.
- RUN, per edge:
  - If tick: p←0.
    - cnt!=term: cnt←cnt+1 (up) or cnt−1 (down).
    - cnt==term and auto_l=1: cnt←sv, remain RUN.
    - cnt==term and auto_l=0: cnt holds term, go to DONE.
  - Else: p←p+1.
  - hold=1 with no start/stop: go to HOLD. That edge's tick/step still occurs if tick is high.
- HOLD:
  - p and cnt frozen; tick=0, tc=0.
  - hold=0: return to RUN with the same prescaler phase.
- DONE: cnt holds term, done=1, busy=0. Leave only via start (→RUN) or stop (→IDLE).
- Timing:
  - One-shot period from the start edge to the DONE transition is (lim+1)·(div+1) edges.
  - Auto-reload tc period is (lim+1)·(div+1) cycles.
- Boundaries:
  - lim=0: cnt=term immediately. tc on the first tick; one-shot enters DONE after div+1 edges.
  - div=0: tick is continuously high in RUN.
  - No wrap past lim or below 0. The count never leaves [0, lim_l].
  - clr asserted mid-operation: immediate reset values; any pending tc/done is lost.
  - start with hold=1 in the same cycle: enter RUN. hold is acted on at the next edge.

Test Plan:
- Reset: clr=0 mid-RUN with cnt=2 → cnt=0, busy=0, done=0 without waiting for a clock edge. Release clr → IDLE held.
- One-shot up: lim=3, div=0, dir=1, auto_rl=0, start pulse.
  - cnt 0→1→2→3 on successive edges; tc=1 in the cycle with cnt=3.
  - Next edge: DONE, done=1, cnt stays 3, busy=0.
- Auto-reload down: lim=2, div=2, dir=0, auto_rl=1.
  - cnt 2,1,0 each held 3 cycles; tc one cycle every 9 cycles.
  - cnt reloads to 2; busy stays 1; done never set.
- Hold: W=4, lim=15, div=1, up. Assert hold at cnt=5 for 6 cycles.
  - cnt=5, tick=0 throughout; prescaler phase preserved.
  - Resume reaches cnt=15 exactly 6 cycles later than the unheld run.
- Priority/restart:
  - start+stop in the same cycle during RUN → IDLE, cnt=0.
  - start alone during RUN at cnt=7 with new lim=4, dir=0 → cnt=4 next edge, counting down.
- Edge limits:
  - lim=0, div=0, one-shot → tc on the first RUN cycle, DONE next edge, cnt=0.
  - lim=15 up → cnt reaches 15 and never wraps to 0 in one-shot mode.
